// File: rtl/enc_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the encoder homing sequencer and its index path:
//   - count-mode encodings driven to the quadrature decoder
//   - fault codes reported in the status block
//   - sequencer state enum
//   - mode legality helper
// -----------------------------------------------------------------------------
package enc_pkg;

    // Count modes understood by the decoder's cnt_setting input
    localparam logic [2:0] ENC_MODE_X1 = 3'd0;
    localparam logic [2:0] ENC_MODE_X2 = 3'd1;
    localparam logic [2:0] ENC_MODE_X4 = 3'd2;

    // Fault codes
    localparam logic [1:0] ENC_FLT_NONE    = 2'd0;
    localparam logic [1:0] ENC_FLT_MODE    = 2'd1;
    localparam logic [1:0] ENC_FLT_TIMEOUT = 2'd2;

    // Homing sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SEEK   = 3'd2,
        ST_LATCH  = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } enc_state_t;

    // Only x1/x2/x4 exist; everything above x4 is rejected
    function automatic logic enc_mode_legal(input logic [2:0] mode);
        return (mode <= ENC_MODE_X4);
    endfunction

endpackage

// File: rtl/enc_index_sync.sv
// -----------------------------------------------------------------------------
// enc_index_sync
// Brings the asynchronous encoder Z input into the clock domain and produces a
// one-cycle pulse on each rising edge of the (optionally filtered) level.
//
// Build option: ENC_INDEX_FILTER_EN
//   defined   - the synchronized level must hold for IDX_FILT consecutive
//               samples before the filtered level follows it (both polarities);
//               the edge is taken on the filtered level.
//   undefined - the edge is taken directly on the synchronized level.
//
// Ports:
//   clock        in   clock
//   reset        in   asynchronous active-low reset
//   i_index_raw  in   raw encoder index (Z), asynchronous
//   o_rise       out  one-cycle pulse on an index rising edge
// -----------------------------------------------------------------------------
module enc_index_sync #(
    parameter int IDX_FILT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_index_raw,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_lvl_prev;
    logic w_level;

    // Two-flop synchronizer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_index_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef ENC_INDEX_FILTER_EN
    localparam logic [3:0] FILT_LAST = 4'(IDX_FILT - 1);

    logic       r_filt;
    logic [3:0] r_filt_cnt;

    // The counter tracks how long the synchronized level has disagreed with
    // the filtered level; any agreement restarts it, so only an unbroken run
    // of IDX_FILT samples flips the filtered level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_filt     <= 1'b0;
            r_filt_cnt <= 4'd0;
        end else if (r_sync2 == r_filt) begin
            r_filt_cnt <= 4'd0;
        end else if (r_filt_cnt == FILT_LAST) begin
            r_filt     <= r_sync2;
            r_filt_cnt <= 4'd0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 4'd1;
        end
    end

    assign w_level = r_filt;
`else
    // Filter depth is irrelevant here; an out-of-range value still blocks the
    // index path so a misconfigured build cannot home silently.
    localparam logic FILT_OK = (IDX_FILT >= 1) && (IDX_FILT <= 15);

    assign w_level = r_sync2 & FILT_OK;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lvl_prev <= 1'b0;
        end else begin
            r_lvl_prev <= w_level;
        end
    end

    assign o_rise = w_level & ~r_lvl_prev;

endmodule

// File: rtl/encoder_home_seq.sv
// -----------------------------------------------------------------------------
// encoder_home_seq
// Homing sequencer and position accumulator for the quadrature decoder.
// On cmd_start it programs the decoder count mode, waits SETTLE_CYC cycles for
// the decoder pipeline, then seeks a fresh index rise and zeroes the position,
// capturing the pre-zero value in home_pos. Steps are accumulated continuously
// (except in the single latch cycle).
//
// Build option: ENC_INDEX_FILTER_EN (index glitch filter, see enc_index_sync).
//
// Ports:
//   clock        in   clock
//   reset        in   asynchronous active-low reset
//   step         in   one-cycle count event from the decoder
//   dir          in   0 = forward (+1), 1 = reverse (-1); valid with step
//   index_raw    in   asynchronous encoder Z input
//   cmd_start    in   start-homing pulse
//   cmd_abort    in   abort pulse (wins over cmd_start)
//   cfg_mode     in   requested count mode: 0 x1, 1 x2, 2 x4, others illegal
//   cfg_timeout  in   seek timeout in cycles, 0 = wait forever
//   cnt_setting  out  count mode driven to the decoder
//   position     out  accumulated position, two's complement, wraps
//   home_pos     out  position captured at the zeroing instant
//   busy         out  sequence in progress (SETTLE/SEEK/LATCH)
//   homed        out  last sequence completed
//   fault        out  last sequence failed
//   fault_code   out  0 none, 1 illegal mode, 2 timeout
// -----------------------------------------------------------------------------
module encoder_home_seq
    import enc_pkg::*;
#(
    parameter int POS_W      = 32,
    parameter int SETTLE_CYC = 4,
    parameter int TIMEOUT_W  = 24,
    parameter int IDX_FILT   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 step,
    input  logic                 dir,
    input  logic                 index_raw,
    input  logic                 cmd_start,
    input  logic                 cmd_abort,
    input  logic [2:0]           cfg_mode,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    output logic [2:0]           cnt_setting,
    output logic [POS_W-1:0]     position,
    output logic [POS_W-1:0]     home_pos,
    output logic                 busy,
    output logic                 homed,
    output logic                 fault,
    output logic [1:0]           fault_code
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

    enc_state_t           r_state;
    logic [7:0]           r_settle_cnt;
    logic [TIMEOUT_W-1:0] r_tmo_cnt;
    logic [2:0]           r_cnt_setting;
    logic [POS_W-1:0]     r_position;
    logic [POS_W-1:0]     r_home_pos;
    logic                 r_busy;
    logic                 r_homed;
    logic                 r_fault;
    logic [1:0]           r_fault_code;
    logic                 w_index_rise;
    logic                 w_tmo_hit;

    enc_index_sync #(
        .IDX_FILT (IDX_FILT)
    ) u_index_sync (
        .clock       (clock),
        .reset       (reset),
        .i_index_raw (index_raw),
        .o_rise      (w_index_rise)
    );

    // >= rather than == so that lowering cfg_timeout mid-seek still trips
    assign w_tmo_hit = (cfg_timeout != '0) && (r_tmo_cnt >= cfg_timeout);

    // Sequencer with registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_settle_cnt  <= 8'd0;
            r_tmo_cnt     <= '0;
            r_cnt_setting <= ENC_MODE_X1;
            r_busy        <= 1'b0;
            r_homed       <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_code  <= ENC_FLT_NONE;
        end else if (cmd_abort) begin
            // fault, fault_code and cnt_setting deliberately survive an abort
            r_state      <= ST_IDLE;
            r_settle_cnt <= 8'd0;
            r_tmo_cnt    <= '0;
            r_busy       <= 1'b0;
            r_homed      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_FAULT: begin
                    if (cmd_start) begin
                        if (!enc_mode_legal(cfg_mode)) begin
                            r_state      <= ST_FAULT;
                            r_homed      <= 1'b0;
                            r_fault      <= 1'b1;
                            r_fault_code <= ENC_FLT_MODE;
                        end else begin
                            r_state       <= ST_SETTLE;
                            r_cnt_setting <= cfg_mode;
                            r_settle_cnt  <= 8'd0;
                            r_busy        <= 1'b1;
                            r_homed       <= 1'b0;
                            r_fault       <= 1'b0;
                            r_fault_code  <= ENC_FLT_NONE;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_state      <= ST_SEEK;
                        r_settle_cnt <= 8'd0;
                        r_tmo_cnt    <= '0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 8'd1;
                    end
                end

                ST_SEEK: begin
                    if (w_index_rise) begin
                        r_state <= ST_LATCH;
                    end else if (w_tmo_hit) begin
                        r_state      <= ST_FAULT;
                        r_busy       <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_code <= ENC_FLT_TIMEOUT;
                    end else if (r_tmo_cnt != '1) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                ST_LATCH: begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_homed <= 1'b1;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Position accumulator; the latch cycle zeroes it and drops any step
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_position <= '0;
            r_home_pos <= '0;
        end else if (r_state == ST_LATCH) begin
            r_home_pos <= r_position;
            r_position <= '0;
        end else if (step) begin
            if (dir) begin
                r_position <= r_position - 1'b1;
            end else begin
                r_position <= r_position + 1'b1;
            end
        end
    end

    assign cnt_setting = r_cnt_setting;
    assign position    = r_position;
    assign home_pos    = r_home_pos;
    assign busy        = r_busy;
    assign homed       = r_homed;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;

endmodule

// File: tb/tb_encoder_home_seq.sv
module tb_encoder_home_seq;

    localparam int POS_W     = 32;
    localparam int TIMEOUT_W = 24;
`ifdef ENC_INDEX_FILTER_EN
    localparam int EXTRA = 4;
`else
    localparam int EXTRA = 0;
`endif

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 step = 1'b0;
    logic                 dir = 1'b0;
    logic                 index_raw = 1'b0;
    logic                 cmd_start = 1'b0;
    logic                 cmd_abort = 1'b0;
    logic [2:0]           cfg_mode = 3'd0;
    logic [TIMEOUT_W-1:0] cfg_timeout = '0;
    logic [2:0]           cnt_setting;
    logic [POS_W-1:0]     position;
    logic [POS_W-1:0]     home_pos;
    logic                 busy;
    logic                 homed;
    logic                 fault;
    logic [1:0]           fault_code;

    int n_vec = 0;
    int n_err = 0;

    encoder_home_seq dut (
        .clock       (clock),
        .reset       (reset),
        .step        (step),
        .dir         (dir),
        .index_raw   (index_raw),
        .cmd_start   (cmd_start),
        .cmd_abort   (cmd_abort),
        .cfg_mode    (cfg_mode),
        .cfg_timeout (cfg_timeout),
        .cnt_setting (cnt_setting),
        .position    (position),
        .home_pos    (home_pos),
        .busy        (busy),
        .homed       (homed),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_cmd(input logic [2:0] mode);
        cfg_mode  = mode;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        $display("reset asserted");
        n_vec++; if (position !== 32'd0)   begin n_err++; $display("FAIL rst_position: got %h want %h", position, 32'd0); end
        n_vec++; if (home_pos !== 32'd0)   begin n_err++; $display("FAIL rst_home_pos: got %h want %h", home_pos, 32'd0); end
        n_vec++; if (cnt_setting !== 3'd0) begin n_err++; $display("FAIL rst_cnt_setting: got %0d want 0", cnt_setting); end
        n_vec++; if (busy !== 1'b0)        begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (homed !== 1'b0)       begin n_err++; $display("FAIL rst_homed: got %b want 0", homed); end
        n_vec++; if (fault !== 1'b0)       begin n_err++; $display("FAIL rst_fault: got %b want 0", fault); end
        n_vec++; if (fault_code !== 2'd0)  begin n_err++; $display("FAIL rst_fault_code: got %0d want 0", fault_code); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_count_forward();
        $display("10 forward steps");
        step = 1'b1; dir = 1'b0;
        repeat (10) tick();
        step = 1'b0;
        n_vec++; if (position !== 32'd10)  begin n_err++; $display("FAIL fwd_position: got %0d want 10", position); end
        n_vec++; if (busy !== 1'b0 || homed !== 1'b0 || fault !== 1'b0 || fault_code !== 2'd0) begin
            n_err++; $display("FAIL fwd_flags: got busy=%b homed=%b fault=%b code=%0d want all 0", busy, homed, fault, fault_code);
        end
        n_vec++; if (cnt_setting !== 3'd0) begin n_err++; $display("FAIL fwd_cnt_setting: got %0d want 0", cnt_setting); end
    endtask

    task automatic test_home_x4();
        $display("home x4, 27 more steps then index");
        cfg_timeout = '0;
        start_cmd(3'd2);
        n_vec++; if (busy !== 1'b1)        begin n_err++; $display("FAIL hx4_busy_start: got %b want 1", busy); end
        n_vec++; if (cnt_setting !== 3'd2) begin n_err++; $display("FAIL hx4_cnt_setting: got %0d want 2", cnt_setting); end
        step = 1'b1; dir = 1'b0;
        repeat (27) tick();
        step = 1'b0;
        n_vec++; if (position !== 32'd37)  begin n_err++; $display("FAIL hx4_pos_pre: got %0d want 37", position); end
        index_raw = 1'b1;                  // cycle m
        repeat (2 + EXTRA) tick();         // m+2: edge just detected, still seeking
        n_vec++; if (busy !== 1'b1 || homed !== 1'b0) begin n_err++; $display("FAIL hx4_m2: got busy=%b homed=%b want 1/0", busy, homed); end
        tick();                            // m+3: LATCH
        n_vec++; if (busy !== 1'b1 || position !== 32'd37) begin n_err++; $display("FAIL hx4_latch: got busy=%b pos=%0d want 1/37", busy, position); end
        tick();                            // m+4: DONE
        n_vec++; if (homed !== 1'b1)       begin n_err++; $display("FAIL hx4_homed: got %b want 1", homed); end
        n_vec++; if (busy !== 1'b0)        begin n_err++; $display("FAIL hx4_busy_end: got %b want 0", busy); end
        n_vec++; if (position !== 32'd0)   begin n_err++; $display("FAIL hx4_position: got %0d want 0", position); end
        n_vec++; if (home_pos !== 32'd37)  begin n_err++; $display("FAIL hx4_home_pos: got %0d want 37", home_pos); end
        index_raw = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_illegal_mode();
        $display("start with illegal mode 5");
        start_cmd(3'd5);
        n_vec++; if (fault !== 1'b1)       begin n_err++; $display("FAIL ill_fault: got %b want 1", fault); end
        n_vec++; if (fault_code !== 2'd1)  begin n_err++; $display("FAIL ill_code: got %0d want 1", fault_code); end
        n_vec++; if (busy !== 1'b0)        begin n_err++; $display("FAIL ill_busy: got %b want 0", busy); end
        n_vec++; if (cnt_setting !== 3'd2) begin n_err++; $display("FAIL ill_cnt_setting: got %0d want 2", cnt_setting); end
        tick();
        n_vec++; if (busy !== 1'b0 || fault !== 1'b1) begin n_err++; $display("FAIL ill_hold: got busy=%b fault=%b want 0/1", busy, fault); end
    endtask

    task automatic test_timeout();
        $display("timeout 100, no index");
        cfg_timeout = 24'd100;
        start_cmd(3'd0);
        n_vec++; if (fault !== 1'b0 || fault_code !== 2'd0) begin n_err++; $display("FAIL tmo_clear: got fault=%b code=%0d want 0/0", fault, fault_code); end
        n_vec++; if (cnt_setting !== 3'd0) begin n_err++; $display("FAIL tmo_cnt_setting: got %0d want 0", cnt_setting); end
        repeat (4) tick();                 // SEEK entry cycle s
        repeat (100) tick();               // s+100
        n_vec++; if (fault !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL tmo_early: got fault=%b busy=%b want 0/1", fault, busy); end
        tick();                            // s+101
        n_vec++; if (fault !== 1'b1)       begin n_err++; $display("FAIL tmo_fault: got %b want 1", fault); end
        n_vec++; if (fault_code !== 2'd2)  begin n_err++; $display("FAIL tmo_code: got %0d want 2", fault_code); end
        n_vec++; if (busy !== 1'b0)        begin n_err++; $display("FAIL tmo_busy: got %b want 0", busy); end
    endtask

    task automatic test_no_timeout_abort();
        bit seen_fault;
        $display("timeout 0 for 10000 cycles, then abort");
        cfg_timeout = '0;
        start_cmd(3'd0);
        repeat (4) tick();
        seen_fault = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (fault !== 1'b0 || busy !== 1'b1) seen_fault = 1'b1;
        end
        n_vec++; if (seen_fault !== 1'b0)  begin n_err++; $display("FAIL notmo_fault: got %b want 0", seen_fault); end
        start_cmd(3'd2);                   // ignored while busy
        n_vec++; if (cnt_setting !== 3'd0 || busy !== 1'b1) begin n_err++; $display("FAIL busy_start: got cnt=%0d busy=%b want 0/1", cnt_setting, busy); end
        step = 1'b1; dir = 1'b0;
        repeat (3) tick();
        step = 1'b0;
        cmd_abort = 1'b1; cmd_start = 1'b1; cfg_mode = 3'd1;
        tick();
        cmd_abort = 1'b0; cmd_start = 1'b0;
        n_vec++; if (busy !== 1'b0 || homed !== 1'b0) begin n_err++; $display("FAIL abort_idle: got busy=%b homed=%b want 0/0", busy, homed); end
        n_vec++; if (position !== 32'd3)   begin n_err++; $display("FAIL abort_pos: got %0d want 3", position); end
        n_vec++; if (cnt_setting !== 3'd0) begin n_err++; $display("FAIL abort_cnt_setting: got %0d want 0", cnt_setting); end
        tick();
        n_vec++; if (busy !== 1'b0)        begin n_err++; $display("FAIL abort_wins: got busy=%b want 0", busy); end
    endtask

    task automatic test_wrap();
        $display("reverse/forward across zero");
        step = 1'b1; dir = 1'b1;
        repeat (3) tick();
        n_vec++; if (position !== 32'd0)          begin n_err++; $display("FAIL wrap_zero: got %h want 0", position); end
        tick();
        n_vec++; if (position !== 32'hFFFF_FFFF)  begin n_err++; $display("FAIL wrap_under: got %h want ffffffff", position); end
        dir = 1'b0;
        tick();
        step = 1'b0;
        n_vec++; if (position !== 32'd0)          begin n_err++; $display("FAIL wrap_over: got %h want 0", position); end
    endtask

    task automatic test_index_pulse();
        $display("home x2 with short index pulse");
        start_cmd(3'd1);
        step = 1'b1; dir = 1'b1;
        repeat (5) tick();
        step = 1'b0;
`ifdef ENC_INDEX_FILTER_EN
        index_raw = 1'b1;
        repeat (3) tick();
        index_raw = 1'b0;
        repeat (12) tick();
        n_vec++; if (busy !== 1'b1 || homed !== 1'b0) begin n_err++; $display("FAIL glitch: got busy=%b homed=%b want 1/0", busy, homed); end
        index_raw = 1'b1;                  // cycle m, 4-cycle pulse
        repeat (4) tick();
        index_raw = 1'b0;
        repeat (3) tick();                 // m+7
        n_vec++; if (homed !== 1'b0)       begin n_err++; $display("FAIL pulse_early: got homed=%b want 0", homed); end
        tick();                            // m+8
`else
        index_raw = 1'b1;                  // cycle m, 1-cycle pulse
        tick();
        index_raw = 1'b0;
        repeat (2) tick();                 // m+3
        n_vec++; if (homed !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL pulse_early: got homed=%b busy=%b want 0/1", homed, busy); end
        tick();                            // m+4
`endif
        n_vec++; if (homed !== 1'b1)             begin n_err++; $display("FAIL pulse_homed: got %b want 1", homed); end
        n_vec++; if (home_pos !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL pulse_home_pos: got %h want fffffffb", home_pos); end
        n_vec++; if (position !== 32'd0)         begin n_err++; $display("FAIL pulse_position: got %h want 0", position); end
    endtask

    task automatic test_async_reset();
        $display("reset mid-settle");
        start_cmd(3'd2);
        step = 1'b1; dir = 1'b0;
        tick();
        step = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0 || homed !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL arst_flags: got busy=%b homed=%b fault=%b want 0", busy, homed, fault); end
        n_vec++; if (cnt_setting !== 3'd0) begin n_err++; $display("FAIL arst_cnt_setting: got %0d want 0", cnt_setting); end
        n_vec++; if (position !== 32'd0 || home_pos !== 32'd0) begin n_err++; $display("FAIL arst_pos: got pos=%h home=%h want 0/0", position, home_pos); end
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_count_forward();
        test_home_x4();
        test_illegal_mode();
        test_timeout();
        test_no_timeout_abort();
        test_wrap();
        test_index_pulse();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
